bp_sac_coh_concentrator: RTL and testbench

//  Parametrised N-channel coherence-link concentrator for SAC/accelerator tiles.

---
 rtl/bp_common_pkg.sv | 29 ++
 rtl/bp_sac_packet_tracker.sv | 63 ++++++
 rtl/bp_sac_coh_concentrator.sv | 195 +++++++++++++++++++
 tb/tb_bp_sac_coh_concentrator.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// Shared definitions for the SAC coherence concentrator: header field
// offsets, the packet FSM state encoding and a small wrap helper.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_conc_idle = 2'd0,
    e_conc_busy = 2'd1,
    e_conc_drop = 2'd2
  } conc_state_e;

  // Header layout: cord in the LSBs, len directly above it, cid above len.
  function automatic int cord_lsb();
    return 0;
  endfunction

  function automatic int len_lsb(input int cord_width);
    return cord_width;
  endfunction

  function automatic int cid_lsb(input int cord_width, input int len_width);
    return cord_width + len_width;
  endfunction

  // Next channel index in round-robin order.
  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/bp_sac_packet_tracker.sv
// Tracks one wormhole packet: on a header handshake with len>0 it locks the
// header's id and counts body flits down to the end of the packet.
module bp_sac_packet_tracker
  import bp_common_pkg::*;
#(
  parameter int len_width_p = 4,
  parameter int id_width_p  = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   hs_i,
  input  logic [len_width_p-1:0] hdr_len_i,
  input  logic [id_width_p-1:0]  hdr_id_i,
  output logic                   busy_o,
  output logic                   last_o,
  output logic [id_width_p-1:0]  lock_o
);

  conc_state_e            state_reg, state_next;
  logic [len_width_p-1:0] cnt_reg, cnt_next;
  logic [id_width_p-1:0]  lock_reg, lock_next;

  // State, remaining-body counter and locked id registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= e_conc_idle;
      cnt_reg   <= '0;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lock_reg  <= lock_next;
    end
  end

  // Header with a body opens a packet; the last body flit closes it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_next  = lock_reg;
    case (state_reg)
      e_conc_idle: begin
        if (hs_i && hdr_len_i != '0) begin
          state_next = e_conc_busy;
          cnt_next   = hdr_len_i;
          lock_next  = hdr_id_i;
        end
      end
      e_conc_busy: begin
        if (hs_i) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == len_width_p'(1)) state_next = e_conc_idle;
        end
      end
      default: state_next = e_conc_idle;
    endcase
  end

  assign busy_o = (state_reg == e_conc_busy);
  assign last_o = busy_o && (cnt_reg == len_width_p'(1));
  assign lock_o = lock_reg;

endmodule

// File: rtl/bp_sac_coh_concentrator.sv
// N-channel coherence link concentrator: round-robin merge of tile flit
// streams with packet locking onto one link through a 2-entry buffer, and
// zero-latency steering of return flits to the channel named by header cid.
module bp_sac_coh_concentrator
  import bp_common_pkg::*;
#(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p*flit_width_p-1:0] in_data_i,
  input  logic [num_in_p-1:0]              in_v_i,
  output logic [num_in_p-1:0]              in_ready_and_o,
  output logic [flit_width_p-1:0]          out_data_o,
  output logic                             out_v_o,
  input  logic                             out_ready_and_i,
  input  logic [flit_width_p-1:0]          ret_data_i,
  input  logic                             ret_v_i,
  output logic                             ret_ready_and_o,
  output logic [num_in_p*flit_width_p-1:0] ret_data_o,
  output logic [num_in_p-1:0]              ret_v_o,
  input  logic [num_in_p-1:0]              ret_ready_and_i,
  output logic                             err_o
);

  localparam int len_lsb_lp = len_lsb(cord_width_p);
  localparam int cid_lsb_lp = cid_lsb(cord_width_p, len_width_p);

  // ---------------- concentrate direction ----------------
  logic [cid_width_p-1:0]  ptr_reg, ptr_next, grant, sel, conc_lock;
  logic                    grant_v, sel_ok, sel_in_v, enq, deq, full;
  logic                    conc_busy, conc_last;
  logic [flit_width_p-1:0] sel_data;
  logic [len_width_p-1:0]  conc_len;
  logic [flit_width_p-1:0] buf_mem [2];
  logic                    wr_ptr_reg, rd_ptr_reg;
  logic [1:0]              count_reg;

  // Round robin: first valid channel at or after the pointer.
  always_comb begin
    grant_v = 1'b0;
    grant   = ptr_reg;
    for (int k = 0; k < num_in_p; k++) begin
      for (int i = 0; i < num_in_p; i++) begin
        if (!grant_v && in_v_i[i] && (((int'(ptr_reg) + k) % num_in_p) == i)) begin
          grant_v = 1'b1;
          grant   = cid_width_p'(i);
        end
      end
    end
  end

  assign sel    = conc_busy ? conc_lock : grant;
  assign sel_ok = conc_busy || grant_v;
  assign full   = (count_reg == 2'd2);

  // Select the served channel's flit and drive its ready; others stay low.
  always_comb begin
    sel_data       = '0;
    sel_in_v       = 1'b0;
    in_ready_and_o = '0;
    for (int i = 0; i < num_in_p; i++) begin
      if (sel == cid_width_p'(i)) begin
        sel_data          = in_data_i[i*flit_width_p +: flit_width_p];
        sel_in_v          = in_v_i[i];
        in_ready_and_o[i] = !reset_i && sel_ok && !full;
      end
    end
  end

  assign enq      = !reset_i && sel_ok && sel_in_v && !full;
  assign deq      = out_v_o && out_ready_and_i;
  assign conc_len = sel_data[len_lsb_lp +: len_width_p];

  bp_sac_packet_tracker #(
    .len_width_p(len_width_p),
    .id_width_p (cid_width_p)
  ) conc_tracker (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .hs_i     (enq),
    .hdr_len_i(conc_len),
    .hdr_id_i (grant),
    .busy_o   (conc_busy),
    .last_o   (conc_last),
    .lock_o   (conc_lock)
  );

  // Pointer moves past a channel once its whole packet has been accepted.
  always_comb begin
    ptr_next = ptr_reg;
    if (enq && !conc_busy && conc_len == '0)
      ptr_next = cid_width_p'(wrap_inc(int'(grant), num_in_p));
    else if (enq && conc_last)
      ptr_next = cid_width_p'(wrap_inc(int'(conc_lock), num_in_p));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_reg <= '0;
    else         ptr_reg <= ptr_next;
  end

  // Two-entry output buffer; simultaneous enq/deq keeps one flit per cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (enq) begin
        buf_mem[wr_ptr_reg] <= sel_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign out_v_o    = (count_reg != 2'd0);
  assign out_data_o = buf_mem[rd_ptr_reg];

  // ---------------- deconcentrate direction ----------------
  conc_state_e            dec_state_reg, dec_state_next;
  logic [cid_width_p-1:0] ret_cid, ret_target, ret_lock;
  logic [len_width_p-1:0] ret_len;
  logic                   ret_busy, ret_last, ret_bad, ret_hs, ret_sel_ready, err_reg;

  assign ret_cid    = ret_data_i[cid_lsb_lp +: cid_width_p];
  assign ret_len    = ret_data_i[len_lsb_lp +: len_width_p];
  assign ret_target = ret_busy ? ret_lock : ret_cid;
  // A header naming a nonexistent channel, and its body, are swallowed.
  assign ret_bad    = (dec_state_reg == e_conc_drop) ||
                      (dec_state_reg == e_conc_idle && int'(ret_cid) >= num_in_p);

  // Steer valid to the target channel and take ready from it.
  always_comb begin
    ret_v_o       = '0;
    ret_sel_ready = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      if (ret_target == cid_width_p'(i)) begin
        ret_v_o[i]    = !reset_i && ret_v_i && !ret_bad;
        ret_sel_ready = ret_ready_and_i[i];
      end
    end
  end

  assign ret_ready_and_o = !reset_i && (ret_bad || ret_sel_ready);
  assign ret_hs          = ret_v_i && ret_ready_and_o;
  assign ret_data_o      = {num_in_p{ret_data_i}};

  bp_sac_packet_tracker #(
    .len_width_p(len_width_p),
    .id_width_p (cid_width_p)
  ) ret_tracker (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .hs_i     (ret_hs),
    .hdr_len_i(ret_len),
    .hdr_id_i (ret_cid),
    .busy_o   (ret_busy),
    .last_o   (ret_last),
    .lock_o   (ret_lock)
  );

  // Deconcentrate state register and sticky bad-cid flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dec_state_reg <= e_conc_idle;
      err_reg       <= 1'b0;
    end else begin
      dec_state_reg <= dec_state_next;
      if (ret_hs && dec_state_reg == e_conc_idle && ret_bad) err_reg <= 1'b1;
    end
  end

  // Header opens a routed or dropped packet; the last body flit ends it.
  always_comb begin
    dec_state_next = dec_state_reg;
    case (dec_state_reg)
      e_conc_idle:
        if (ret_hs && ret_len != '0) dec_state_next = ret_bad ? e_conc_drop : e_conc_busy;
      e_conc_busy, e_conc_drop:
        if (ret_hs && ret_last) dec_state_next = e_conc_idle;
      default: dec_state_next = e_conc_idle;
    endcase
  end

  assign err_o = err_reg;

endmodule

// File: tb/tb_bp_sac_coh_concentrator.sv
// Self-checking bench for bp_sac_coh_concentrator (num_in_p=2, 64-bit flits).
// Expected flits go to scoreboard queues when stimulus is queued; a monitor
// pops and compares on every output handshake.
module tb_bp_sac_coh_concentrator;
  localparam int N  = 2;
  localparam int FW = 64;

  typedef struct packed {
    logic [1:0]    ch;
    logic [FW-1:0] data;
  } ret_exp_t;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*FW-1:0] in_data_i;
  logic [N-1:0]    in_v_i, in_ready_and_o;
  logic [FW-1:0]   out_data_o;
  logic            out_v_o, out_ready_and_i;
  logic [FW-1:0]   ret_data_i;
  logic            ret_v_i, ret_ready_and_o;
  logic [N*FW-1:0] ret_data_o;
  logic [N-1:0]    ret_v_o, ret_ready_and_i;
  logic            err_o;

  always #5 clk = ~clk;

  bp_sac_coh_concentrator dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_data_i(in_data_i), .in_v_i(in_v_i), .in_ready_and_o(in_ready_and_o),
    .out_data_o(out_data_o), .out_v_o(out_v_o), .out_ready_and_i(out_ready_and_i),
    .ret_data_i(ret_data_i), .ret_v_i(ret_v_i), .ret_ready_and_o(ret_ready_and_o),
    .ret_data_o(ret_data_o), .ret_v_o(ret_v_o), .ret_ready_and_i(ret_ready_and_i),
    .err_o(err_o)
  );

  int checks = 0;
  int passes = 0;
  int acc0 = 0;
  int out_seen = 0;
  int ret_seen = 0;

  logic [FW-1:0] in_q0[$], in_q1[$], ret_q[$], exp_out[$];
  ret_exp_t      exp_ret[$];
  logic [N-1:0]  in_hs = '0;
  logic          ret_hs_s = 1'b0;
  logic          rst_drv = 1'b1, out_rdy_drv = 1'b1;
  logic [N-1:0]  ret_rdy_drv = '1;

  function automatic logic [FW-1:0] hdr(input logic [1:0] cid, input logic [3:0] len);
    logic [FW-1:0] f;
    f = {$urandom(), $urandom()};
    f[10:7]  = len;
    f[12:11] = cid;
    return f;
  endfunction

  function automatic logic [FW-1:0] body();
    return {$urandom(), $urandom()};
  endfunction

  // One clock: retire last cycle's handshakes, drive, sample at negedge.
  task automatic cycle();
    @(posedge clk); #1;
    if (in_hs[0]) begin void'(in_q0.pop_front()); acc0++; end
    if (in_hs[1]) void'(in_q1.pop_front());
    if (ret_hs_s) void'(ret_q.pop_front());
    reset_i         = rst_drv;
    out_ready_and_i = out_rdy_drv;
    ret_ready_and_i = ret_rdy_drv;
    in_v_i[0]         = (in_q0.size() > 0);
    in_data_i[63:0]   = in_v_i[0] ? in_q0[0] : '0;
    in_v_i[1]         = (in_q1.size() > 0);
    in_data_i[127:64] = in_v_i[1] ? in_q1[0] : '0;
    ret_v_i    = (ret_q.size() > 0);
    ret_data_i = ret_v_i ? ret_q[0] : '0;
    @(negedge clk);
    in_hs    = in_v_i & in_ready_and_o;
    ret_hs_s = ret_v_i & ret_ready_and_o;
  endtask

  task automatic do_reset();
    rst_drv = 1'b1; out_rdy_drv = 1'b1; ret_rdy_drv = '1;
    in_q0.delete(); in_q1.delete(); ret_q.delete();
    exp_out.delete(); exp_ret.delete();
    in_hs = '0; ret_hs_s = 1'b0;
    cycle(); cycle();
    rst_drv = 1'b0;
    cycle();
  endtask

  // Scoreboard monitor: compare every output handshake against the queues.
  logic [FW-1:0] mon_exp;
  ret_exp_t      mon_r;
  logic [1:0]    mon_ch;
  always @(negedge clk) begin
    if (!reset_i && out_v_o && out_ready_and_i) begin
      checks++; out_seen++;
      if (exp_out.size() == 0) begin
        $display("FAIL out_flit: got %h, required no flit", out_data_o);
      end else begin
        mon_exp = exp_out.pop_front();
        if (out_data_o !== mon_exp) $display("FAIL out_flit: got %h, required %h", out_data_o, mon_exp);
        else begin passes++; $display("out flit %h", out_data_o); end
      end
    end
    if (!reset_i && ret_v_o != '0) begin
      mon_ch = (ret_v_o == 2'b10) ? 2'd1 : 2'd0;
      if (ret_v_o == 2'b11) begin
        checks++;
        $display("FAIL ret_onehot: got %b, required one-hot", ret_v_o);
      end else if (ret_ready_and_i[mon_ch[0]]) begin
        checks++; ret_seen++;
        if (exp_ret.size() == 0) begin
          $display("FAIL ret_flit: got ch%0d %h, required no flit", mon_ch, ret_data_o[mon_ch[0]*FW +: FW]);
        end else begin
          mon_r = exp_ret.pop_front();
          if (mon_ch !== mon_r.ch || ret_data_o[mon_ch[0]*FW +: FW] !== mon_r.data)
            $display("FAIL ret_flit: got ch%0d %h, required ch%0d %h",
                     mon_ch, ret_data_o[mon_ch[0]*FW +: FW], mon_r.ch, mon_r.data);
          else begin passes++; $display("ret flit ch%0d %h", mon_ch, mon_r.data); end
        end
      end
    end
  end

  task automatic test_reset();
    logic [FW-1:0] h;
    rst_drv = 1'b1;
    h = hdr(2'd0, 4'd0);
    in_q0.push_back(h);
    ret_q.push_back(h);
    cycle(); cycle();
    checks++; if (out_v_o !== 1'b0) $display("FAIL reset_out_v: got %b, required 0", out_v_o); else passes++;
    checks++; if (ret_v_o !== 2'b00) $display("FAIL reset_ret_v: got %b, required 00", ret_v_o); else passes++;
    checks++; if (in_ready_and_o !== 2'b00) $display("FAIL reset_in_ready: got %b, required 00", in_ready_and_o); else passes++;
    checks++; if (ret_ready_and_o !== 1'b0) $display("FAIL reset_ret_ready: got %b, required 0", ret_ready_and_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b, required 0", err_o); else passes++;
    in_q0.delete(); ret_q.delete();
    rst_drv = 1'b0;
    cycle();
    checks++; if (out_v_o !== 1'b0) $display("FAIL post_reset_out_v: got %b, required 0", out_v_o); else passes++;
  endtask

  task automatic test_single_header();
    logic [FW-1:0] h, h0, h1;
    do_reset();
    h = hdr(2'd0, 4'd0);
    in_q0.push_back(h); exp_out.push_back(h);
    cycle();
    checks++; if (in_hs !== 2'b01 || out_v_o !== 1'b0)
      $display("FAIL single_accept: got hs=%b out_v=%b, required hs=01 out_v=0", in_hs, out_v_o); else passes++;
    cycle();
    checks++; if (out_v_o !== 1'b1 || out_data_o !== h)
      $display("FAIL single_latency: got v=%b %h, required v=1 %h", out_v_o, out_data_o, h); else passes++;
    h0 = hdr(2'd0, 4'd0); h1 = hdr(2'd1, 4'd0);
    in_q0.push_back(h0); in_q1.push_back(h1);
    exp_out.push_back(h1); exp_out.push_back(h0);
    cycle();
    checks++; if (in_ready_and_o !== 2'b10)
      $display("FAIL ptr_advance: got ready %b, required 10", in_ready_and_o); else passes++;
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (exp_out.size() != 0)
      $display("FAIL ptr_drain: got %0d pending, required 0", exp_out.size()); else passes++;
  endtask

  task automatic load_two_packets();
    logic [FW-1:0] f;
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 3; j++) begin
        f = (j == 0) ? hdr(2'(c), 4'd2) : body();
        if (c == 0) in_q0.push_back(f); else in_q1.push_back(f);
        exp_out.push_back(f);
      end
    end
  endtask

  task automatic test_two_packets();
    int viol = 0;
    int n = 0;
    do_reset();
    load_two_packets();
    while (exp_out.size() > 0 && n < 40) begin
      cycle(); n++;
      if (in_q0.size() > 0 && in_ready_and_o[1] !== 1'b0) viol++;
    end
    checks++; if (exp_out.size() != 0)
      $display("FAIL two_pkt_drain: got %0d pending after %0d cycles, required 0", exp_out.size(), n); else passes++;
    checks++; if (viol != 0)
      $display("FAIL two_pkt_lock: got %0d cycles with ch1 ready, required 0", viol); else passes++;
  endtask

  task automatic test_stall();
    int viol = 0, unstable = 0, n = 0, base, stall = -1;
    logic [FW-1:0] held;
    do_reset();
    base = out_seen;
    load_two_packets();
    while ((exp_out.size() > 0 || in_q1.size() > 0) && n < 60) begin
      cycle(); n++;
      if (in_q0.size() > 0 && in_ready_and_o[1] !== 1'b0) viol++;
      if (stall < 0 && out_seen - base >= 2) begin
        out_rdy_drv = 1'b0; stall = 0;
      end else if (stall >= 0 && stall < 5) begin
        if (stall == 0) held = out_data_o;
        else if (out_v_o !== 1'b1 || out_data_o !== held) unstable++;
        stall++;
        if (stall == 5) begin
          checks++; if (in_ready_and_o !== 2'b00)
            $display("FAIL stall_full: got ready %b, required 00", in_ready_and_o); else passes++;
          out_rdy_drv = 1'b1;
        end
      end
    end
    checks++; if (exp_out.size() != 0 || stall != 5)
      $display("FAIL stall_drain: got %0d pending stall=%0d, required 0 and 5", exp_out.size(), stall); else passes++;
    checks++; if (viol != 0)
      $display("FAIL stall_lock: got %0d cycles with ch1 ready, required 0", viol); else passes++;
    checks++; if (unstable != 0)
      $display("FAIL stall_hold: got %0d unstable cycles, required 0", unstable); else passes++;
  endtask

  task automatic test_ret_route();
    int viol = 0, n = 0, base;
    logic [FW-1:0] f;
    ret_exp_t e;
    do_reset();
    base = ret_seen;
    for (int j = 0; j < 4; j++) begin
      f = (j == 0) ? hdr(2'd1, 4'd3) : body();
      ret_q.push_back(f);
      e.ch = 2'd1; e.data = f;
      exp_ret.push_back(e);
    end
    while (ret_q.size() > 0 && n < 20) begin
      cycle();
      if (ret_v_o[0] !== 1'b0) viol++;
      if (n == 2) ret_rdy_drv = 2'b01;
      if (n == 3) begin
        checks++; if (ret_ready_and_o !== 1'b0 || ret_v_o !== 2'b10)
          $display("FAIL ret_backpressure: got ready=%b v=%b, required 0 10", ret_ready_and_o, ret_v_o); else passes++;
        ret_rdy_drv = 2'b11;
      end
      n++;
    end
    checks++; if (ret_seen - base != 4 || exp_ret.size() != 0)
      $display("FAIL ret_route_count: got %0d flits %0d pending, required 4 0", ret_seen - base, exp_ret.size()); else passes++;
    checks++; if (viol != 0)
      $display("FAIL ret_route_ch0: got %0d cycles ret_v_o[0]=1, required 0", viol); else passes++;
  endtask

  task automatic test_ret_drop();
    int viol = 0, n = 0, taken = 0;
    logic [FW-1:0] f;
    ret_exp_t e;
    do_reset();
    ret_q.push_back(hdr(2'd3, 4'd2));
    ret_q.push_back(body());
    ret_q.push_back(body());
    while (ret_q.size() > 0 && n < 20) begin
      cycle(); n++;
      if (ret_v_i && (ret_v_o !== 2'b00 || ret_ready_and_o !== 1'b1)) viol++;
      if (ret_hs_s) taken++;
    end
    checks++; if (taken != 3)
      $display("FAIL drop_count: got %0d consumed, required 3", taken); else passes++;
    checks++; if (viol != 0)
      $display("FAIL drop_route: got %0d bad cycles, required 0", viol); else passes++;
    checks++; if (err_o !== 1'b1) $display("FAIL drop_err: got %b, required 1", err_o); else passes++;
    f = hdr(2'd0, 4'd0);
    ret_q.push_back(f);
    e.ch = 2'd0; e.data = f;
    exp_ret.push_back(e);
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (exp_ret.size() != 0 || err_o !== 1'b1)
      $display("FAIL drop_recover: got %0d pending err=%b, required 0 1", exp_ret.size(), err_o); else passes++;
    do_reset();
    checks++; if (err_o !== 1'b0) $display("FAIL err_clear: got %b, required 0", err_o); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] h, h0, h1, b1;
    int n = 0;
    do_reset();
    acc0 = 0;
    h = hdr(2'd0, 4'd4); b1 = body();
    in_q0.push_back(h); in_q0.push_back(b1);
    for (int j = 0; j < 3; j++) in_q0.push_back(body());
    h1 = hdr(2'd1, 4'd0);
    in_q1.push_back(h1);
    exp_out.push_back(h); exp_out.push_back(b1);
    while (!(in_hs[0] && acc0 == 1) && n < 20) begin cycle(); n++; end
    checks++; if (n >= 20) $display("FAIL midrst_reach: got timeout, required body1 handshake"); else passes++;
    rst_drv = 1'b1;
    cycle();
    in_q0.delete(); exp_out.delete();
    exp_out.push_back(h1);
    rst_drv = 1'b0;
    cycle();
    checks++; if (out_v_o !== 1'b0 || ret_v_o !== 2'b00)
      $display("FAIL midrst_valids: got out_v=%b ret_v=%b, required 0 00", out_v_o, ret_v_o); else passes++;
    checks++; if (in_ready_and_o !== 2'b10)
      $display("FAIL midrst_grant: got ready %b, required 10", in_ready_and_o); else passes++;
    h0 = hdr(2'd0, 4'd0);
    in_q0.push_back(h0); exp_out.push_back(h0);
    n = 0;
    while (exp_out.size() > 0 && n < 10) begin cycle(); n++; end
    checks++; if (exp_out.size() != 0)
      $display("FAIL midrst_drain: got %0d pending, required 0", exp_out.size()); else passes++;
  endtask

  initial begin
    reset_i = 1'b1; in_data_i = '0; in_v_i = '0; out_ready_and_i = 1'b1;
    ret_data_i = '0; ret_v_i = 1'b0; ret_ready_and_i = '1;
    test_reset();
    test_single_header();
    test_two_packets();
    test_stall();
    test_ret_route();
    test_ret_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
